// File: rtl/lut2lut_stim_chk.sv
// lut2lut_stim_chk: stimulus generator and latency-aligned checker for the registered AND8 benchmark
//   clock0     : sole clock, rising edge
//   reset      : synchronous, active-high
//   start      : begin a run, honoured in IDLE and DONE only
//   stim       : registered 8-bit vector to the benchmark (bit0 -> in1 ... bit7 -> in8)
//   dut_out    : benchmark registered output (out1)
//   busy       : run or drain in progress
//   done       : results valid and held
//   pass       : done with zero mismatches
//   vec_count  : vectors issued this run
//   err_count  : saturating mismatch count this run
module lut2lut_stim_chk #(
   parameter int unsigned NUM_VECTORS = 256,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5,
   parameter int unsigned DUT_LATENCY = 2,
   parameter int unsigned ERR_W       = 16
) (
   input  logic             clock0,
   input  logic             reset,
   input  logic             start,
   output logic [7:0]       stim,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      vec_count,
   output logic [ERR_W-1:0] err_count
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam logic [7:0]       SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   // vector 0 is the seed itself, so the register already holds the next step when the run begins
   localparam logic [7:0]       SEED_NXT   = SEED[0] ? ((SEED >> 1) ^ 8'hB8) : (SEED >> 1);
   localparam logic [15:0]      LAST       = 16'(NUM_VECTORS - 1);
   localparam logic [15:0]      DRAIN_LAST = 16'(DUT_LATENCY - 1);
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;
   state_t                 state;
   logic [7:0]             lfsr;
   logic [7:0]             lfsr_nxt;
   logic [15:0]            drain_cnt;
   logic [DUT_LATENCY-1:0] exp_vld;
   logic [DUT_LATENCY-1:0] exp_bit;
   logic                   mismatch;
   logic [ERR_W-1:0]       err_nxt;
   assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);
   // the oldest pipeline entry lines up with the benchmark response for that vector
   assign mismatch = exp_vld[DUT_LATENCY-1] && (dut_out != exp_bit[DUT_LATENCY-1]);
   assign err_nxt  = (mismatch && err_count != ERR_MAX) ? err_count + ERR_W'(1) : err_count;
   always_ff @(posedge clock0) begin
      if (reset) begin
         state     <= IDLE;
         stim      <= '0;
         lfsr      <= SEED;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         vec_count <= '0;
         err_count <= '0;
         drain_cnt <= '0;
         exp_vld   <= '0;
         exp_bit   <= '0;
      end else begin
         exp_vld[0] <= state == RUN;
         exp_bit[0] <= &stim;
         for (int i = 1; i < DUT_LATENCY; i++) begin
            exp_vld[i] <= exp_vld[i-1];
            exp_bit[i] <= exp_bit[i-1];
         end
         err_count <= err_nxt;
         case (state)
            IDLE, DONE: if (start) begin
               state     <= RUN;
               stim      <= SEED;
               lfsr      <= SEED_NXT;
               busy      <= 1'b1;
               done      <= 1'b0;
               pass      <= 1'b0;
               vec_count <= '0;
               err_count <= '0;
            end
            RUN: begin
               vec_count <= vec_count + 16'd1;
               lfsr      <= lfsr_nxt;
               if (vec_count == LAST) begin
                  state     <= DRAIN;
                  stim      <= '0;
                  drain_cnt <= '0;
               end else begin
                  // next vector index is vec_count+1; every fourth one is forced all-ones
                  stim <= (vec_count[1:0] == 2'd2) ? 8'hFF : lfsr;
               end
            end
            DRAIN: if (drain_cnt == DRAIN_LAST) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= err_nxt == '0;
            end else begin
               drain_cnt <= drain_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end
endmodule
